// File: rtl/rvx_core_data_memory_unit_pkg.sv
// Shared constants for the RVX data-memory unit: access-size codes,
// FSM state encoding and the alignment rule used when issuing requests.
package rvx_core_data_memory_unit_pkg;

  localparam logic [1:0] RVX_LOAD_SIZE_BYTE = 2'b00;
  localparam logic [1:0] RVX_LOAD_SIZE_HALF = 2'b01;
  localparam logic [1:0] RVX_LOAD_SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    RVX_MEM_STATE_IDLE     = 2'b00,
    RVX_MEM_STATE_REQUEST  = 2'b01,
    RVX_MEM_STATE_RESPONSE = 2'b10
  } rvx_mem_state_e;

  // Half accesses need an even address, word accesses a multiple of four.
  function automatic logic rvx_is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic result;
    result = 1'b0;
    if (size == RVX_LOAD_SIZE_HALF) result = offset[0];
    else if (size == RVX_LOAD_SIZE_WORD) result = |offset;
    return result;
  endfunction

endpackage

// File: rtl/rvx_core_store_unit.sv
// Store lane replication: builds byte enables and replicated write data
// so the bus sees the store value on every lane the strobe can select.
module rvx_core_store_unit
  import rvx_core_data_memory_unit_pkg::*;
(
  input  logic [1:0]  access_size_i,
  input  logic [1:0]  byte_offset_i,
  input  logic [31:0] store_data_i,
  output logic [3:0]  write_strobe_o,
  output logic [31:0] write_data_o
);

  // Strobe selects the addressed lanes; data is copied into all lanes.
  always_comb begin
    write_strobe_o = 4'b1111;
    write_data_o   = store_data_i;
    case (access_size_i)
      RVX_LOAD_SIZE_BYTE: begin
        write_strobe_o = 4'b0001 << byte_offset_i;
        write_data_o   = {4{store_data_i[7:0]}};
      end
      RVX_LOAD_SIZE_HALF: begin
        write_strobe_o = 4'b0011 << {byte_offset_i[1], 1'b0};
        write_data_o   = {2{store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rvx_core_data_memory_unit.sv
// Data-memory request unit: alignment check, request/response bus FSM,
// pipeline stall generation and stage-2 capture of load data and fields.
module rvx_core_data_memory_unit
  import rvx_core_data_memory_unit_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load_request_s1,
  input  logic        store_request_s1,
  input  logic [1:0]  access_size_s1,
  input  logic        load_unsigned_s1,
  input  logic [31:0] target_address_s1,
  input  logic [31:0] store_data_s1,
  output logic [31:0] mem_address,
  output logic        mem_read_request,
  output logic        mem_write_request,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_write_strobe,
  input  logic        mem_request_ready,
  input  logic [31:0] mem_read_data,
  input  logic        mem_response_valid,
  output logic        stall_mem,
  output logic        misaligned_load,
  output logic        misaligned_store,
  output logic [31:0] read_data_s2,
  output logic [1:0]  load_size_s2,
  output logic        load_unsigned_s2,
  output logic [1:0]  target_address_1_0_s2
);

  rvx_mem_state_e state_q, state_d;

  logic [31:0] mem_address_q;
  logic [31:0] mem_write_data_q;
  logic [3:0]  mem_write_strobe_q;
  logic        is_write_q;
  logic [31:0] read_data_q;
  logic [1:0]  load_size_q;
  logic        load_unsigned_q;
  logic [1:0]  offset_q;

  logic        any_request;
  logic        misaligned;
  logic        in_idle;
  logic        aligned_request;
  logic        response_done;
  logic        stall_int;
  logic [3:0]  store_strobe;
  logic [31:0] store_data;

  rvx_core_store_unit u_store_unit (
    .access_size_i  (access_size_s1),
    .byte_offset_i  (target_address_s1[1:0]),
    .store_data_i   (store_data_s1),
    .write_strobe_o (store_strobe),
    .write_data_o   (store_data)
  );

  // Request qualification and stall; a response completes either in
  // RESPONSE or, on a zero-wait bus, in the REQUEST cycle itself.
  always_comb begin
    any_request     = load_request_s1 | store_request_s1;
    misaligned      = rvx_is_misaligned(access_size_s1, target_address_s1[1:0]);
    in_idle         = (state_q == RVX_MEM_STATE_IDLE);
    aligned_request = in_idle & any_request & ~misaligned;
    response_done   = mem_response_valid &
                      ((state_q == RVX_MEM_STATE_RESPONSE) |
                       ((state_q == RVX_MEM_STATE_REQUEST) & mem_request_ready));
    stall_int       = (~in_idle & ~response_done) | aligned_request;
  end

  // Next-state logic for the single-outstanding bus transaction.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RVX_MEM_STATE_IDLE: begin
        if (aligned_request) state_d = RVX_MEM_STATE_REQUEST;
      end
      RVX_MEM_STATE_REQUEST: begin
        if (mem_request_ready) begin
          state_d = mem_response_valid ? RVX_MEM_STATE_IDLE : RVX_MEM_STATE_RESPONSE;
        end
      end
      RVX_MEM_STATE_RESPONSE: begin
        if (mem_response_valid) state_d = RVX_MEM_STATE_IDLE;
      end
      default: state_d = RVX_MEM_STATE_IDLE;
    endcase
  end

  // State register; reset abandons any outstanding transaction.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= RVX_MEM_STATE_IDLE;
    else          state_q <= state_d;
  end

  // Bus request fields are captured once at issue and held until done.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_address_q      <= 32'h0;
      mem_write_data_q   <= 32'h0;
      mem_write_strobe_q <= 4'h0;
      is_write_q         <= 1'b0;
    end else if (aligned_request) begin
      mem_address_q      <= {target_address_s1[31:2], 2'b00};
      mem_write_data_q   <= store_request_s1 ? store_data : 32'h0;
      mem_write_strobe_q <= store_request_s1 ? store_strobe : 4'h0;
      is_write_q         <= store_request_s1;
    end
  end

  // Stage-2 capture: read word on load completion, fields whenever the
  // pipeline advances.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read_data_q     <= 32'h0;
      load_size_q     <= RVX_LOAD_SIZE_WORD;
      load_unsigned_q <= 1'b0;
      offset_q        <= 2'b00;
    end else begin
      if (response_done && !is_write_q) read_data_q <= mem_read_data;
      if (!stall_int) begin
        load_size_q     <= access_size_s1;
        load_unsigned_q <= load_unsigned_s1;
        offset_q        <= target_address_s1[1:0];
      end
    end
  end

  // Combinational outputs are forced low while reset is asserted.
  always_comb begin
    stall_mem         = reset_n & stall_int;
    misaligned_load   = reset_n & in_idle & load_request_s1 & misaligned;
    misaligned_store  = reset_n & in_idle & store_request_s1 & misaligned;
    mem_read_request  = (state_q == RVX_MEM_STATE_REQUEST) & ~is_write_q;
    mem_write_request = (state_q == RVX_MEM_STATE_REQUEST) & is_write_q;
  end

  assign mem_address           = mem_address_q;
  assign mem_write_data        = mem_write_data_q;
  assign mem_write_strobe      = mem_write_strobe_q;
  assign read_data_s2          = read_data_q;
  assign load_size_s2          = load_size_q;
  assign load_unsigned_s2      = load_unsigned_q;
  assign target_address_1_0_s2 = offset_q;

endmodule

// File: tb/tb_rvx_core_data_memory_unit.sv
// Self-checking bench for rvx_core_data_memory_unit: directed scenarios
// plus randomized transactions against a transaction-level model.
module tb_rvx_core_data_memory_unit;
  import rvx_core_data_memory_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        load_request_s1, store_request_s1, load_unsigned_s1;
  logic [1:0]  access_size_s1;
  logic [31:0] target_address_s1, store_data_s1;
  logic [31:0] mem_address, mem_write_data, mem_read_data, read_data_s2;
  logic        mem_read_request, mem_write_request, mem_request_ready, mem_response_valid;
  logic [3:0]  mem_write_strobe;
  logic        stall_mem, misaligned_load, misaligned_store, load_unsigned_s2;
  logic [1:0]  load_size_s2, target_address_1_0_s2;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_rdata = 32'h0;

  always #5 clock = ~clock;

  rvx_core_data_memory_unit dut (
    .clock(clock), .reset_n(reset_n),
    .load_request_s1(load_request_s1), .store_request_s1(store_request_s1),
    .access_size_s1(access_size_s1), .load_unsigned_s1(load_unsigned_s1),
    .target_address_s1(target_address_s1), .store_data_s1(store_data_s1),
    .mem_address(mem_address), .mem_read_request(mem_read_request),
    .mem_write_request(mem_write_request), .mem_write_data(mem_write_data),
    .mem_write_strobe(mem_write_strobe), .mem_request_ready(mem_request_ready),
    .mem_read_data(mem_read_data), .mem_response_valid(mem_response_valid),
    .stall_mem(stall_mem), .misaligned_load(misaligned_load),
    .misaligned_store(misaligned_store), .read_data_s2(read_data_s2),
    .load_size_s2(load_size_s2), .load_unsigned_s2(load_unsigned_s2),
    .target_address_1_0_s2(target_address_1_0_s2)
  );

  // One complete access: drives stage-1 and bus inputs cycle by cycle and
  // checks bus outputs, stall length and stage-2 results against the model.
  task automatic run_txn(input bit is_store, input logic [1:0] size, input bit uns,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input int ready_wait, input int valid_wait, input bit zero_wait,
                         input logic [31:0] rdata);
    bit          mis;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    int          stalls, exp_stalls;
    mis = (size == RVX_LOAD_SIZE_HALF && (addr % 2) != 0) ||
          (size == RVX_LOAD_SIZE_WORD && (addr % 4) != 0);
    if (size == RVX_LOAD_SIZE_BYTE) begin
      exp_strb  = 4'(1 << (addr % 4));
      exp_wdata = 32'(sdata[7:0]) * 32'h0101_0101;
    end else if (size == RVX_LOAD_SIZE_HALF) begin
      exp_strb  = 4'(3 << (addr & 2));
      exp_wdata = 32'(sdata[15:0]) * 32'h0001_0001;
    end else begin
      exp_strb  = 4'hF;
      exp_wdata = sdata;
    end
    $display("txn %s size=%0d uns=%0d addr=%h data=%h rw=%0d vw=%0d zw=%0d mis=%0d",
             is_store ? "ST" : "LD", size, uns, addr, sdata, ready_wait, valid_wait, zero_wait, mis);

    load_request_s1 = !is_store; store_request_s1 = is_store;
    access_size_s1 = size; load_unsigned_s1 = uns;
    target_address_s1 = addr; store_data_s1 = sdata;
    mem_request_ready = 1'b0; mem_response_valid = 1'b0;
    @(negedge clock);
    n_checks++;
    if (read_data_s2 !== exp_rdata) begin
      n_fail++;
      $display("FAIL idle_rdata: got %h expected %h", read_data_s2, exp_rdata);
    end

    if (mis) begin
      n_checks++;
      if ({misaligned_load, misaligned_store, stall_mem, mem_read_request, mem_write_request}
          !== {!is_store, is_store, 3'b000}) begin
        n_fail++;
        $display("FAIL misaligned_issue: got mis_ld=%b mis_st=%b stall=%b rd=%b wr=%b expected mis_ld=%b mis_st=%b stall=0 rd=0 wr=0",
                 misaligned_load, misaligned_store, stall_mem, mem_read_request, mem_write_request, !is_store, is_store);
      end
      @(posedge clock); #1;
      load_request_s1 = 1'b0; store_request_s1 = 1'b0;
      @(negedge clock);
      n_checks++;
      if ({misaligned_load, misaligned_store, mem_read_request, mem_write_request, stall_mem} !== 5'b0) begin
        n_fail++;
        $display("FAIL misaligned_after: got mis_ld=%b mis_st=%b rd=%b wr=%b stall=%b expected all 0",
                 misaligned_load, misaligned_store, mem_read_request, mem_write_request, stall_mem);
      end
      n_checks++;
      if ({load_size_s2, load_unsigned_s2, target_address_1_0_s2} !== {size, uns, addr[1:0]}) begin
        n_fail++;
        $display("FAIL misaligned_s2: got size=%0d uns=%b off=%0d expected size=%0d uns=%b off=%0d",
                 load_size_s2, load_unsigned_s2, target_address_1_0_s2, size, uns, addr[1:0]);
      end
      @(posedge clock); #1;
      return;
    end

    stalls = 0;
    n_checks++;
    if ({stall_mem, misaligned_load, misaligned_store, mem_read_request, mem_write_request} !== 5'b10000) begin
      n_fail++;
      $display("FAIL issue_cycle: got stall=%b mis_ld=%b mis_st=%b rd=%b wr=%b expected stall=1 others 0",
               stall_mem, misaligned_load, misaligned_store, mem_read_request, mem_write_request);
    end
    if (stall_mem) stalls++;
    @(posedge clock); #1;

    for (int i = 0; i <= ready_wait; i++) begin
      mem_request_ready  = (i == ready_wait);
      mem_response_valid = (i == ready_wait) ? zero_wait : 1'($urandom % 2);
      mem_read_data      = (i == ready_wait && zero_wait) ? rdata : $urandom;
      @(negedge clock);
      n_checks++;
      if ({mem_read_request, mem_write_request} !== {!is_store, is_store}) begin
        n_fail++;
        $display("FAIL request_level: cycle %0d got rd=%b wr=%b expected rd=%b wr=%b",
                 i, mem_read_request, mem_write_request, !is_store, is_store);
      end
      n_checks++;
      if (mem_address !== {addr[31:2], 2'b00}) begin
        n_fail++;
        $display("FAIL request_address: cycle %0d got %h expected %h", i, mem_address, {addr[31:2], 2'b00});
      end
      if (is_store) begin
        n_checks++;
        if (mem_write_strobe !== exp_strb || mem_write_data !== exp_wdata) begin
          n_fail++;
          $display("FAIL store_lanes: cycle %0d got strb=%b data=%h expected strb=%b data=%h",
                   i, mem_write_strobe, mem_write_data, exp_strb, exp_wdata);
        end
      end
      if (stall_mem) stalls++;
      @(posedge clock); #1;
    end

    if (!zero_wait) begin
      for (int i = 0; i <= valid_wait; i++) begin
        mem_request_ready  = 1'($urandom % 2);
        mem_response_valid = (i == valid_wait);
        mem_read_data      = (i == valid_wait) ? rdata : $urandom;
        @(negedge clock);
        n_checks++;
        if ({mem_read_request, mem_write_request} !== 2'b00) begin
          n_fail++;
          $display("FAIL response_request_low: cycle %0d got rd=%b wr=%b expected 0 0",
                   i, mem_read_request, mem_write_request);
        end
        if (stall_mem) stalls++;
        @(posedge clock); #1;
      end
    end

    if (!is_store) exp_rdata = rdata;
    exp_stalls = 1 + ready_wait + (zero_wait ? 0 : 1 + valid_wait);
    n_checks++;
    if (stalls != exp_stalls) begin
      n_fail++;
      $display("FAIL stall_cycles: got %0d expected %0d", stalls, exp_stalls);
    end

    load_request_s1 = 1'b0; store_request_s1 = 1'b0;
    mem_request_ready = 1'b0;
    mem_response_valid = 1'b1;   // stray response in IDLE must be ignored
    mem_read_data = $urandom;
    @(negedge clock);
    n_checks++;
    if (read_data_s2 !== exp_rdata) begin
      n_fail++;
      $display("FAIL read_data_s2: got %h expected %h", read_data_s2, exp_rdata);
    end
    n_checks++;
    if ({load_size_s2, load_unsigned_s2, target_address_1_0_s2, stall_mem} !== {size, uns, addr[1:0], 1'b0}) begin
      n_fail++;
      $display("FAIL s2_fields: got size=%0d uns=%b off=%0d stall=%b expected size=%0d uns=%b off=%0d stall=0",
               load_size_s2, load_unsigned_s2, target_address_1_0_s2, stall_mem, size, uns, addr[1:0]);
    end
    @(posedge clock); #1;
    mem_response_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    load_request_s1 = 0; store_request_s1 = 0; access_size_s1 = 0; load_unsigned_s1 = 0;
    target_address_s1 = 0; store_data_s1 = 0;
    mem_request_ready = 0; mem_read_data = 0; mem_response_valid = 0;
    repeat (3) @(posedge clock);
    #1;
    @(negedge clock);
    n_checks++;
    if ({mem_address, mem_read_request, mem_write_request, mem_write_data, mem_write_strobe,
         stall_mem, misaligned_load, misaligned_store, read_data_s2, load_unsigned_s2,
         target_address_1_0_s2} !== '0 || load_size_s2 !== RVX_LOAD_SIZE_WORD) begin
      n_fail++;
      $display("FAIL reset_state: got addr=%h rd=%b wr=%b wdata=%h strb=%b stall=%b rdata=%h size=%0d expected zeros and size=%0d",
               mem_address, mem_read_request, mem_write_request, mem_write_data, mem_write_strobe,
               stall_mem, read_data_s2, load_size_s2, RVX_LOAD_SIZE_WORD);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    exp_rdata = 32'h0;
  endtask

  task automatic test_reset_mid_response();
    $display("txn LW 0x40 with reset in RESPONSE");
    load_request_s1 = 1; store_request_s1 = 0; access_size_s1 = RVX_LOAD_SIZE_WORD;
    load_unsigned_s1 = 0; target_address_s1 = 32'h40;
    mem_request_ready = 0; mem_response_valid = 0;
    @(posedge clock); #1;
    mem_request_ready = 1;
    @(posedge clock); #1;
    mem_request_ready = 0;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_address, mem_read_request, mem_write_request, stall_mem, misaligned_load, read_data_s2} !== '0 ||
        load_size_s2 !== RVX_LOAD_SIZE_WORD) begin
      n_fail++;
      $display("FAIL reset_mid_response: got addr=%h rd=%b wr=%b stall=%b rdata=%h size=%0d expected zeros size=%0d",
               mem_address, mem_read_request, mem_write_request, stall_mem, read_data_s2, load_size_s2, RVX_LOAD_SIZE_WORD);
    end
    @(posedge clock); #1;
    load_request_s1 = 0;
    reset_n = 1'b1;
    exp_rdata = 32'h0;
    mem_response_valid = 1; mem_read_data = 32'h1234_5678;
    @(negedge clock);
    n_checks++;
    if ({stall_mem, mem_read_request, mem_write_request} !== 3'b000) begin
      n_fail++;
      $display("FAIL late_response_state: got stall=%b rd=%b wr=%b expected 0 0 0",
               stall_mem, mem_read_request, mem_write_request);
    end
    @(posedge clock); #1;
    mem_response_valid = 0;
    @(negedge clock);
    n_checks++;
    if (read_data_s2 !== 32'h0) begin
      n_fail++;
      $display("FAIL late_response_rdata: got %h expected 00000000", read_data_s2);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_load_word();
    run_txn(0, RVX_LOAD_SIZE_WORD, 0, 32'h0000_1000, 32'h0, 0, 0, 0, 32'hDEAD_BEEF);
  endtask

  task automatic test_store_byte();
    run_txn(1, RVX_LOAD_SIZE_BYTE, 0, 32'h0000_2003, 32'h0000_00A5, 0, 0, 0, 32'h0);
  endtask

  task automatic test_store_half_wait();
    run_txn(1, RVX_LOAD_SIZE_HALF, 0, 32'h0000_3002, 32'h1234_BEEF, 5, 2, 0, 32'h0);
  endtask

  task automatic test_misaligned();
    run_txn(0, RVX_LOAD_SIZE_HALF, 0, 32'h0000_0001, 32'h0, 0, 0, 0, 32'h0);
    run_txn(0, RVX_LOAD_SIZE_WORD, 0, 32'h0000_0006, 32'h0, 0, 0, 0, 32'h0);
    run_txn(1, RVX_LOAD_SIZE_WORD, 0, 32'h0000_0102, 32'h5555_AAAA, 0, 0, 0, 32'h0);
  endtask

  task automatic test_zero_wait();
    run_txn(0, RVX_LOAD_SIZE_BYTE, 1, 32'h0000_0102, 32'h0, 0, 0, 1, 32'hCAFE_F00D);
  endtask

  task automatic test_back_to_back();
    run_txn(1, RVX_LOAD_SIZE_WORD, 0, 32'h0000_4000, 32'h0BAD_F00D, 0, 0, 1, 32'h0);
    run_txn(0, RVX_LOAD_SIZE_HALF, 1, 32'h0000_4002, 32'h0, 0, 0, 1, 32'h8765_4321);
    run_txn(1, RVX_LOAD_SIZE_HALF, 0, 32'h0000_4000, 32'h0000_7E57, 1, 1, 0, 32'h0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      run_txn(1'($urandom % 2), 2'($urandom_range(0, 2)), 1'($urandom % 2), $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom % 3 == 0), $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_store_byte();
    test_store_half_wait();
    test_misaligned();
    test_zero_wait();
    test_back_to_back();
    test_random();
    test_reset_mid_response();
    test_load_word();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rvx_core_data_memory_unit.md
# rvx_core_data_memory_unit

Data-memory request unit for the RVX core pipeline. It takes load/store requests from stage 1, checks alignment, drives a request/response data bus, stalls the pipeline while a transaction is outstanding, and registers the returned word for the stage-2 load alignment logic. It also registers the load size, signedness and byte-offset fields that the stage-2 alignment logic consumes.

## Interface
- No parameters. Bus and data width are fixed at 32 bits.

Ports:
- clock  in  1  core clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- load_request_s1  in  1  stage-1 instruction is a load
- store_request_s1  in  1  stage-1 instruction is a store; never high together with load_request_s1
- access_size_s1  in  2  RVX_LOAD_SIZE_BYTE / _HALF / _WORD encoding
- load_unsigned_s1  in  1  LBU/LHU
- target_address_s1  in  32  effective address
- store_data_s1  in  32  rs2 value, right-aligned
- mem_address  out  32  word-aligned bus address, bits [1:0] always 0
- mem_read_request  out  1  read request, held until accepted
- mem_write_request  out  1  write request, held until accepted
- mem_write_data  out  32  lane-replicated store data
- mem_write_strobe  out  4  byte enables
- mem_request_ready  in  1  bus accepts the request this cycle
- mem_read_data  in  32  read response data
- mem_response_valid  in  1  read data valid / write complete
- stall_mem  out  1  freeze stages 0–1
- misaligned_load  out  1  one-cycle exception pulse
- misaligned_store  out  1  one-cycle exception pulse
- read_data_s2  out  32  captured read word
- load_size_s2  out  2  registered access_size_s1
- load_unsigned_s2  out  1  registered load_unsigned_s1
- target_address_1_0_s2  out  2  registered target_address_s1[1:0]

## Operation
- FSM states: IDLE, REQUEST, RESPONSE.
- In IDLE, an access is misaligned when it is half-size with address[0]=1, or word-size with address[1:0]≠0.
- IDLE, aligned request:
  - Latch mem_address = {addr[31:2],2'b00}, the write data, the strobe and the request type.
  - Go to REQUEST.
- IDLE, misaligned request:
  - Pulse the matching misaligned_* output combinationally in the same cycle.
  - Issue no bus request, assert no stall, stay in IDLE.
- REQUEST: mem_*_request is high from the registered state.
  - ready=0: hold all bus outputs stable.
  - ready=1: go to RESPONSE.
  - ready=1 with valid=1 in the same cycle (zero-wait bus): treat as the RESPONSE cycle and go to IDLE.
- RESPONSE:
  - mem_*_request is low.
  - On mem_response_valid, capture read_data_s2 (loads only; it holds its value on stores) and go to IDLE.
- stall_mem = (state≠IDLE) & ~response_done, or IDLE & aligned request. It is combinational.
- Because stall_mem is low in the response cycle, the pipeline advances at that edge. read_data_s2 and the *_s2 fields update at the same edge.
- In cycles without a memory op, load_size_s2, load_unsigned_s2 and target_address_1_0_s2 take the stage-1 values whenever stall_mem=0.
- Store strobe:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1],1'b0}
  - word: 4'b1111
- Store data:
  - byte: {4{d[7:0]}}
  - half: {2{d[15:0]}}
  - word: d
- A mem_response_valid arriving in IDLE or REQUEST (without ready) is ignored.
- Reset mid-transaction:
  - All outputs clear immediately and the state goes to IDLE.
  - The outstanding bus transaction is abandoned and its late response is ignored.
- Reset values:
  - all outputs 0
  - load_size_s2 = RVX_LOAD_SIZE_WORD

## Timing
- Minimum transaction length is 2 cycles: the issue cycle (stall high) and the REQUEST cycle with ready=valid=1 (stall low).
- Typical length is 3 cycles: issue, accept, response.
- Each wait cycle on ready or valid adds one stall cycle.
- Bus outputs are registered. Only stall_mem and misaligned_* are combinational from stage-1 inputs and bus inputs.
- Throughput is one outstanding transaction. A new request is considered only in IDLE.

## Structure
- Add state encodings RVX_MEM_STATE_IDLE/REQUEST/RESPONSE to rvx_core_constants.vh, next to the existing RVX_LOAD_SIZE_* constants.
- Split the combinational strobe/data lane replication into a sub-module, rvx_core_store_unit (access size, addr[1:0], data in → strobe, data out).
- The FSM and the registers stay in the top module.

## Test plan
- LW from 0x0000_1000, ready and valid each after 1 cycle, data 0xDEADBEEF → stall high for 2 cycles; read_data_s2=0xDEADBEEF, load_size_s2=WORD, offset 2'b00.
- SB of 0x000000A5 to 0x2003 → mem_address=0x2000, strobe=4'b1000, wdata=0xA5A5A5A5, one write request.
- SH to 0x3002 with ready held low 5 cycles → request, address and strobe=4'b1100 stable throughout; stall held.
- LH from 0x0001 → misaligned_load pulses 1 cycle; no bus request; stall_mem=0. LW from 0x0006 → same behaviour.
- Zero-wait LBU from 0x0102 (ready=valid=1 in the REQUEST cycle) → 2-cycle transaction; load_unsigned_s2=1, offset 2'b10.
- reset_n low during RESPONSE, then a late valid after release → outputs zero while in reset; state IDLE; late response ignored; read_data_s2 remains 0.
